// File: rtl/jtcop_obj_dma.sv
// Sprite-table DMA for the MXC-06 object path.
// A CPU trigger copies the whole object table from CPU sprite RAM into the
// back half of a double-buffered table RAM. The bank flip happens in vblank
// so the draw engine always reads a stable front bank.
// Interface semantics: there is no valid/ready handshake on this block.
// dma_trig is a fire-and-forget pulse that is latched until serviced,
// buf_we qualifies buf_addr/buf_din in the same cycle, and done is a
// one-cycle pulse in the cycle the new front bank becomes visible.
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          dma_trig,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   buf_addr,
    output logic [DW-1:0] buf_din,
    output logic          buf_we,
    input  logic [AW-1:0] tbl_addr,
    output logic [AW:0]   tbl_rd_addr,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COPY     = 2'd1,
        DRAIN    = 2'd2,
        FLIPWAIT = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [AW:0]   buf_addr_q, buf_addr_d;
    logic          buf_we_q, buf_we_d;
    logic          disp_bank_q, disp_bank_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          flip;

    // State and datapath registers; asynchronous reset discards any partial copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            buf_addr_q  <= '0;
            buf_we_q    <= 1'b0;
            disp_bank_q <= 1'b0;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            buf_addr_q  <= buf_addr_d;
            buf_we_q    <= buf_we_d;
            disp_bank_q <= disp_bank_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: trigger latching, word sequencing and the vblank-gated flip.
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        buf_addr_d  = buf_addr_q;
        buf_we_d    = 1'b0;
        disp_bank_d = disp_bank_q;
        pend_d      = pend_q | dma_trig;
        done_d      = 1'b0;
        flip        = 1'b0;

        case (state_q)
            IDLE: begin
                // A trigger arriving this very cycle is serviced without an
                // extra cycle of latency; it is consumed together with pend.
                if ((pend_q || dma_trig) && !LVBL) begin
                    state_d    = COPY;
                    ram_addr_d = '0;
                    pend_d     = 1'b0;
                end
            end
            COPY: begin
                // The write trails the read by one cycle, matching the
                // one-cycle latency of the sprite RAM. The bank bit is
                // concatenated, never carried into from the word counter.
                buf_we_d   = 1'b1;
                buf_addr_d = {~disp_bank_q, ram_addr_q};
                if (ram_addr_q == LAST_WORD) begin
                    state_d = DRAIN;
                end else begin
                    ram_addr_d = ram_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!LVBL) begin
                    flip = 1'b1;
                end else begin
                    state_d = FLIPWAIT;
                end
            end
            FLIPWAIT: begin
                if (!LVBL) begin
                    flip = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flip) begin
            disp_bank_d = ~disp_bank_q;
            done_d      = 1'b1;
            state_d     = IDLE;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign buf_addr    = buf_addr_q;
    assign buf_we      = buf_we_q;
    // Data passes straight through from the sprite RAM; it is forced to zero
    // outside write cycles so the bus is quiet when idle or in reset.
    assign buf_din     = buf_we_q ? ram_dout : '0;
    assign tbl_rd_addr = {disp_bank_q, tbl_addr};
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma: random sprite RAM contents, directed trigger and
// vblank sequences, expected writes and flip timing derived from the copy rules.
module tb_jtcop_obj_dma;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          lvbl;
  logic          dma_trig;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   buf_addr;
  logic [DW-1:0] buf_din;
  logic          buf_we;
  logic [AW-1:0] tbl_addr;
  logic [AW:0]   tbl_rd_addr;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .LVBL(lvbl), .dma_trig(dma_trig),
    .ram_addr(ram_addr), .ram_dout(ram_dout),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we),
    .tbl_addr(tbl_addr), .tbl_rd_addr(tbl_rd_addr),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU sprite RAM model: registered read, data one clock after address.
  logic [DW-1:0] mem [N];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  // ---------------- monitor logs ----------------
  logic [AW+DW:0] act_q[$];
  int             wr_log[$];
  int             done_log[$];
  int             viol_cnt = 0;

  always @(negedge clk) begin
    if (buf_we) begin
      act_q.push_back({buf_addr, buf_din});
      wr_log.push_back(cyc);
      if (buf_addr[AW] == tbl_rd_addr[AW]) viol_cnt++;
    end
    if (done) done_log.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  int             checks = 0;
  int             failures = 0;
  logic [AW+DW:0] exp_q[$];
  logic           exp_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    tbl_addr = AW'($urandom);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic pulse_trig();
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
  endtask

  task automatic reload_mem();
    foreach (mem[i]) mem[i] = DW'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget, input int n_before);
    int n = 0;
    while (done_log.size() <= n_before && n < budget) begin
      tick();
      sample();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_log.size() > n_before), 32'd1);
  endtask

  // A full copy started in cycle s writes word k of the RAM to {bank,k}
  // in cycle s+k+1, one word per clock.
  task automatic verify_copy(input string tag, input logic bank, input int s, input int base);
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back({bank, AW'(k), mem[k]});
    if (act_q.size() < base + N) begin
      check({tag, "_wr_count"}, 32'(act_q.size() - base), 32'(N));
    end else begin
      for (int i = 0; i < N; i++) check({tag, "_wr"}, 32'(act_q[base+i]), 32'(exp_q.pop_front()));
      check({tag, "_wr_first_cyc"}, 32'(wr_log[base]), 32'(s + 1));
      check({tag, "_wr_last_cyc"}, 32'(wr_log[base+N-1]), 32'(s + N));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, s, s2, f, v, base, nd;
    logic b;
    rst = 1'b1; lvbl = 1'b0; dma_trig = 1'b0; tbl_addr = '0;
    exp_bank = 1'b0;
    reload_mem();

    // Reset state
    tick(); tick(); sample();
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_buf_addr", 32'(buf_addr), 0);
    check("rst_buf_din", 32'(buf_din), 0);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_tbl_rd", 32'(tbl_rd_addr), 32'({1'b0, tbl_addr}));
    tick(); rst = 1'b0;
    while (cyc < 10) tick();

    // Test 1: trigger in vblank at cycle 10, copy into bank 1
    t = cyc; base = act_q.size(); nd = done_log.size();
    dma_trig = 1'b1;
    sample();
    check("t1_idle_at_trig", 32'(busy), 0);
    tick(); dma_trig = 1'b0; s = t + 1;
    sample();
    check("t1_busy_start", 32'(busy), 1);
    check("t1_ram_addr_start", 32'(ram_addr), 0);
    wait_done("t1", 1300, nd);
    check("t1_done_cyc", 32'(done_log[nd]), 32'(s + N + 1));
    check("t1_busy_after", 32'(busy), 0);
    verify_copy("t1", 1'b1, s, base);
    exp_bank = 1'b1;
    repeat (3) tick();
    sample();
    check("t1_done_once", 32'(done_log.size() - nd), 1);
    check("t1_tbl_bank", 32'(tbl_rd_addr), 32'({exp_bank, tbl_addr}));

    // Test 2: trigger in active video waits for vblank, copy into bank 0
    reload_mem();
    lvbl = 1'b1;
    tick();
    base = act_q.size(); nd = done_log.size();
    pulse_trig();
    repeat (40 + $urandom_range(0, 20)) tick();
    sample();
    check("t2_ram_addr_held", 32'(ram_addr), 32'(N - 1));
    check("t2_idle_in_video", 32'(busy), 0);
    check("t2_no_writes", 32'(act_q.size() - base), 0);
    tick(); lvbl = 1'b0; f = cyc;
    sample();
    check("t2_idle_at_vbl_edge", 32'(busy), 0);
    tick(); s = f + 1;
    sample();
    check("t2_busy_start", 32'(busy), 1);
    check("t2_ram_addr_start", 32'(ram_addr), 0);
    wait_done("t2", 1300, nd);
    check("t2_done_cyc", 32'(done_log[nd]), 32'(s + N + 1));
    verify_copy("t2", 1'b0, s, base);
    exp_bank = 1'b0;
    tick(); sample();
    check("t2_tbl_bank", 32'(tbl_rd_addr), 32'({exp_bank, tbl_addr}));

    // Test 3: vblank ends 100 cycles into the copy; flip deferred to next vblank
    reload_mem();
    tick();
    base = act_q.size(); nd = done_log.size();
    t = cyc; pulse_trig(); s = t + 1;
    while (cyc < s + 100) tick();
    lvbl = 1'b1;
    while (cyc < s + N + 80) tick();
    sample();
    check("t3_busy_flipwait", 32'(busy), 1);
    check("t3_no_done", 32'(done_log.size() - nd), 0);
    check("t3_all_written", 32'(act_q.size() - base), 32'(N));
    check("t3_front_kept", 32'(tbl_rd_addr), 32'({exp_bank, tbl_addr}));
    tick(); lvbl = 1'b0; v = cyc;
    wait_done("t3", 10, nd);
    check("t3_done_cyc", 32'(done_log[nd]), 32'(v + 1));
    verify_copy("t3", 1'b1, s, base);
    exp_bank = 1'b1;

    // Test 4: three re-triggers during a copy collapse into one extra copy
    reload_mem();
    tick();
    b = exp_bank;
    base = act_q.size(); nd = done_log.size();
    t = cyc; pulse_trig(); s = t + 1;
    while (cyc < s + $urandom_range(5, 300)) tick();
    pulse_trig();
    while (cyc < s + $urandom_range(400, 700)) tick();
    pulse_trig();
    while (cyc < s + $urandom_range(800, 1000)) tick();
    pulse_trig();
    wait_done("t4a", 1300, nd);
    wait_done("t4b", 1300, nd + 1);
    s2 = s + N + 2;
    check("t4_done1_cyc", 32'(done_log[nd]), 32'(s + N + 1));
    check("t4_done2_cyc", 32'(done_log[nd+1]), 32'(s2 + N + 1));
    verify_copy("t4a", ~b, s, base);
    verify_copy("t4b", b, s2, base + N);
    repeat (20) tick();
    sample();
    check("t4_done_total", 32'(done_log.size() - nd), 2);
    check("t4_idle_after", 32'(busy), 0);
    check("t4_bank_back", 32'(tbl_rd_addr), 32'({b, tbl_addr}));

    // Test 5: trigger in the same cycle as the flip decision
    reload_mem();
    tick();
    b = exp_bank;
    base = act_q.size(); nd = done_log.size();
    t = cyc; pulse_trig(); s = t + 1;
    while (cyc < s + N) tick();
    pulse_trig();
    wait_done("t5a", 20, nd);
    wait_done("t5b", 1300, nd + 1);
    s2 = s + N + 2;
    check("t5_done1_cyc", 32'(done_log[nd]), 32'(s + N + 1));
    check("t5_done2_cyc", 32'(done_log[nd+1]), 32'(s2 + N + 1));
    verify_copy("t5a", ~b, s, base);
    verify_copy("t5b", b, s2, base + N);

    // Test 6: reset at word 512 of a copy, then a clean copy into bank 1
    reload_mem();
    tick();
    t = cyc; pulse_trig(); s = t + 1;
    while (cyc < s + 512) tick();
    rst = 1'b1;
    sample();
    check("t6_rst_we", 32'(buf_we), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_din", 32'(buf_din), 0);
    check("t6_rst_bank", 32'(tbl_rd_addr), 32'({1'b0, tbl_addr}));
    exp_bank = 1'b0;
    tick(); tick(); rst = 1'b0;
    reload_mem();
    repeat (5) tick();
    base = act_q.size(); nd = done_log.size();
    t = cyc; pulse_trig(); s = t + 1;
    wait_done("t6", 1300, nd);
    check("t6_done_cyc", 32'(done_log[nd]), 32'(s + N + 1));
    verify_copy("t6", 1'b1, s, base);
    exp_bank = 1'b1;
    tick(); sample();
    check("t6_tbl_bank", 32'(tbl_rd_addr), 32'({exp_bank, tbl_addr}));

    // Writes must never target the bank the draw engine is reading
    check("front_bank_never_written", 32'(viol_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
